// File: rtl/adder_bist_driver.sv
// -----------------------------------------------------------------------------
// adder_bist_driver
//
// Self-test sequencer for the adder pin interface. It drives pseudo-random
// operand pairs onto the adder inputs and waits a fixed settle time. It then
// samples the adder result and checks it against (a + b) mod 2^WIDTH. Results
// are reported as pass/fail, a saturating error count and a capture of the
// first failing vector.
//
// Parameters
//   WIDTH        operand / sum width
//   LATENCY      extra clk cycles between operand update and sum sampling (0..15)
//   NUM_VECTORS  vectors per run (1..65535)
//   LFSR_SEED    nonzero seed of the 16-bit Fibonacci LFSR (taps 16,14,13,11)
//
// Ports
//   clk        in   1      clock, rising edge
//   rst        in   1      synchronous reset, active-high (wins over start)
//   start      in   1      begins a run when idle or done; ignored while busy
//   a_out      out  WIDTH  operand A (registered)
//   b_out      out  WIDTH  operand B (registered)
//   sum_in     in   WIDTH  adder result
//   busy       out  1      run in progress
//   done       out  1      run complete, held until next start or rst
//   pass       out  1      done with zero mismatches
//   err_count  out  8      mismatch count, saturating at 255
//   vec_count  out  16     vectors checked in the current run
//   fail_a     out  WIDTH  operand A of the first mismatch (0 if none)
//   fail_b     out  WIDTH  operand B of the first mismatch
//   fail_sum   out  WIDTH  sum_in observed at the first mismatch
//
// Configuration
//   ADDER_BIST_FAIL_STOP_EN  when defined, the first mismatch ends the run
//                            and a_out/b_out keep the failing operands.
//                            When undefined, every vector is checked.
// -----------------------------------------------------------------------------
module adder_bist_driver #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned LATENCY     = 1,
  parameter int unsigned NUM_VECTORS = 256,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] a_out,
  output logic [WIDTH-1:0] b_out,
  input  logic [WIDTH-1:0] sum_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [7:0]       err_count,
  output logic [15:0]      vec_count,
  output logic [WIDTH-1:0] fail_a,
  output logic [WIDTH-1:0] fail_b,
  output logic [WIDTH-1:0] fail_sum
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  localparam logic [3:0]  LAT      = 4'(LATENCY);
  localparam logic [15:0] LAST_VEC = 16'(NUM_VECTORS - 1);

  // One step of the right-shifting Fibonacci LFSR. The taps 16,14,13,11 map
  // to bits 0,2,3,5 of the register, and the feedback enters at bit 15.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[15:1]};
  endfunction

  // LFSR bytes become operands: truncated or zero-extended to WIDTH.
  function automatic logic [WIDTH-1:0] fit(input logic [7:0] b8);
    return WIDTH'(b8);
  endfunction

  state_e           state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [3:0]       wait_q, wait_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic [7:0]       err_q, err_d;
  logic [15:0]      vec_q, vec_d;
  logic [WIDTH-1:0] fa_q, fa_d;
  logic [WIDTH-1:0] fb_q, fb_d;
  logic [WIDTH-1:0] fs_q, fs_d;

  logic [WIDTH-1:0] sum_exp;
  logic             mismatch;
  logic             last_vec;
  logic             stop_run;

  always_comb begin
    // NOTE: every variable gets a default before the case statement. Any path
    // that does not assign it then holds its value instead of inferring a latch.
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    wait_d   = wait_q;
    a_d      = a_q;
    b_d      = b_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    err_d    = err_q;
    vec_d    = vec_q;
    fa_d     = fa_q;
    fb_d     = fb_q;
    fs_d     = fs_q;
    stop_run = 1'b0;

    // Same-width addition drops the carry, giving the mod 2^WIDTH reference.
    sum_exp  = a_q + b_q;
    mismatch = (sum_in != sum_exp);
    last_vec = (vec_q == LAST_VEC);

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          // The seed itself is the first vector, and the LFSR runs one step ahead.
          state_d = ST_SETTLE;
          lfsr_d  = lfsr_step(LFSR_SEED);
          a_d     = fit(LFSR_SEED[15:8]);
          b_d     = fit(LFSR_SEED[7:0]);
          wait_d  = 4'd0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          err_d   = 8'd0;
          vec_d   = 16'd0;
          fa_d    = '0;
          fb_d    = '0;
          fs_d    = '0;
        end
      end

      ST_SETTLE: begin
        if (wait_q == LAT) begin
          vec_d = vec_q + 16'd1;
          if (mismatch) begin
            // A zero count before this edge means this mismatch is the first.
            // The count saturates at 255 and never returns to zero within a run.
            if (err_q == 8'd0) begin
              fa_d = a_q;
              fb_d = b_q;
              fs_d = sum_in;
            end
            if (err_q != 8'hFF) begin
              err_d = err_q + 8'd1;
            end
          end

`ifdef ADDER_BIST_FAIL_STOP_EN
          stop_run = last_vec || mismatch;
`else
          stop_run = last_vec;
`endif

          if (stop_run) begin
            // Operands are not reloaded, so a_out/b_out keep the final vector.
            state_d = ST_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == 8'd0);
            wait_d  = 4'd0;
          end else begin
            a_d    = fit(lfsr_q[15:8]);
            b_d    = fit(lfsr_q[7:0]);
            lfsr_d = lfsr_step(lfsr_q);
            wait_d = 4'd0;
          end
        end else begin
          wait_d = wait_q + 4'd1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. All registers
  // then update together on the edge, whatever order the simulator evaluates them in.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: a synchronous reset must cover every register here. This design has
      // no memory arrays, so nothing is left out of reset.
      state_q <= ST_IDLE;
      lfsr_q  <= LFSR_SEED;
      wait_q  <= 4'd0;
      a_q     <= '0;
      b_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 8'd0;
      vec_q   <= 16'd0;
      fa_q    <= '0;
      fb_q    <= '0;
      fs_q    <= '0;
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      wait_q  <= wait_d;
      a_q     <= a_d;
      b_q     <= b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      vec_q   <= vec_d;
      fa_q    <= fa_d;
      fb_q    <= fb_d;
      fs_q    <= fs_d;
    end
  end

  assign a_out     = a_q;
  assign b_out     = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign vec_count = vec_q;
  assign fail_a    = fa_q;
  assign fail_b    = fb_q;
  assign fail_sum  = fs_q;

endmodule
